modbus_req_rx: RTL

- Receive side of the Modbus RTU slave. Consumes bytes from the UART byte receiver and delimits frames by T3.5 bus silence.
- Checks each frame for length, slave address and CRC-16. Presents the decoded request (function code, start address, quantity) to the register-read/response path (tx_crc, response).
- Frames addressed to another slave are dropped silently. Length and CRC failures are flagged.

---
 rtl/modbus_req_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/modbus_req_rx.sv
// Modbus RTU slave receive path: delimits frames by T3.5 line silence,
// checks length, slave address and CRC-16, then presents the decoded
// request (function code, start address, quantity) downstream.
module modbus_req_rx #(
  parameter logic [7:0]  SADDR        = 8'h01,
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned T35_OVERRIDE = 0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  func_code,
  output logic [15:0] start_addr,
  output logic [15:0] quantity,
  output logic        is_bcast,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  // Above 19200 baud the inter-frame gap is fixed at 1.75 ms; below it is
  // 3.5 characters of 11 bits. 64-bit math keeps CLK_FREQ*385 from overflowing.
  localparam longint unsigned T35_CALC =
    (T35_OVERRIDE != 0) ? 64'(T35_OVERRIDE) :
    (BAUD_RATE > 19200) ? (64'(CLK_FREQ) / 64'd1000000) * 64'd1750 :
                          (64'(CLK_FREQ) * 64'd385) / (64'd10 * 64'(BAUD_RATE));
  localparam int unsigned T35 = 32'(T35_CALC);
  localparam int          TW  = $clog2(T35 + 1);
  localparam logic [TW-1:0] T35_V = TW'(T35);

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CRC = 2'b10;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV, CHECK} state_e;

  // One reflected CRC-16 byte step (poly A001, LSB first).
  function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] r;
    r = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    buf_q [0:7];
  logic          store_en;
  logic          load;
  logic          fv_q, fv_d, fe_q, fe_d, bcast_q;
  logic [1:0]    err_q, err_d;
  logic [7:0]    func_q;
  logic [15:0]   sa_q, qty_q;
  logic          silent;
  logic          addr_ok;

  assign silent  = (timer_q == T35_V);
  assign addr_ok = (buf_q[0] == SADDR) || (buf_q[0] == 8'h00);

  // Silence timer: any byte restarts it, otherwise count up to T35 and hold.
  always_comb begin
    if (rx_done)     timer_d = '0;
    else if (silent) timer_d = timer_q;
    else             timer_d = timer_q + 1'b1;
  end

  // Frame FSM next state, byte counting, CRC and the end-of-frame verdict.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    store_en   = 1'b0;
    load       = 1'b0;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      WAIT_IDLE: begin
        if (silent && !rx_done) state_d = IDLE;
      end
      IDLE: begin
        if (rx_done) begin
          store_en   = 1'b1;
          byte_cnt_d = 4'd1;
          crc_d      = crc_upd(16'hFFFF, rx_data);
          state_d    = RECV;
        end
      end
      RECV: begin
        if (rx_done) begin
          // A byte landing as the timer would expire still belongs to this frame.
          store_en = (byte_cnt_q < 4'd8);
          crc_d    = crc_upd(crc_q, rx_data);
          if (byte_cnt_q != 4'd9) byte_cnt_d = byte_cnt_q + 4'd1;
        end else if (silent) begin
          // Verdict is registered on entry to CHECK so the pulse and the
          // decoded fields become visible in the same cycle.
          state_d = CHECK;
          if (addr_ok) begin
            if (byte_cnt_q != 4'd8) begin
              fe_d  = 1'b1;
              err_d = ERR_LEN;
            end else if (crc_q != 16'h0000) begin
              fe_d  = 1'b1;
              err_d = ERR_CRC;
            end else begin
              fv_d = 1'b1;
              load = 1'b1;
            end
          end
        end
      end
      CHECK: begin
        byte_cnt_d = 4'd0;
        crc_d      = 16'hFFFF;
        // A byte here is dropped and the next frame must see a full silence.
        state_d    = rx_done ? WAIT_IDLE : IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // State, timer, counters and output registers.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n_in) begin
      state_q    <= WAIT_IDLE;
      timer_q    <= '0;
      byte_cnt_q <= 4'd0;
      crc_q      <= 16'hFFFF;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      err_q      <= 2'b00;
      func_q     <= 8'h00;
      sa_q       <= 16'h0000;
      qty_q      <= 16'h0000;
      bcast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
      err_q      <= err_d;
      if (load) begin
        func_q  <= buf_q[1];
        sa_q    <= {buf_q[2], buf_q[3]};
        qty_q   <= {buf_q[4], buf_q[5]};
        bcast_q <= (buf_q[0] == 8'h00);
      end
    end
  end

  // Frame byte buffer.
  always_ff @(posedge clk_in) begin
    // NOTE: the buffer has no reset; it is only read after all eight bytes of
    // the current frame have been written, so stale contents never escape.
    if (store_en) buf_q[byte_cnt_q[2:0]] <= rx_data;
  end

  assign func_code   = func_q;
  assign start_addr  = sa_q;
  assign quantity    = qty_q;
  assign is_bcast    = bcast_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign err_code    = err_q;

endmodule
